audio_wave_engine: RTL

//  Parametrised successor to the top-level audio run controller. Sequences codec bring-up
//  (START->INIT->RUNNING/ERROR) with an init timeout and restart. Generates NUM_CH

---
 rtl/audio_wave_engine_if.sv | 33 +++
 rtl/audio_wave_engine.sv | 136 +++++++++++++
 2 files changed

// File: rtl/audio_wave_engine_if.sv
// Signal bundle between the audio run controller and its driver:
// codec bring-up handshake, waveform controls and the sample frame.
interface audio_wave_engine_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int PHASE_W  = 24,
  parameter int ERR_W    = 4
);
  logic                         init_done;
  logic [ERR_W-1:0]             init_error;
  logic                         restart;
  logic                         enable;
  logic [1:0]                   mode;
  logic [NUM_CH*PHASE_W-1:0]    phase_inc;
  logic                         sample_req;
  logic                         init_start;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_out;
  logic                         sample_valid;
  logic [1:0]                   state;
  logic [ERR_W-1:0]             error_code;

  // Driver side: codec status, user controls and DAC requests.
  modport master (
    output init_done, init_error, restart, enable, mode, phase_inc, sample_req,
    input  init_start, sample_out, sample_valid, state, error_code
  );

  // Engine side.
  modport slave (
    input  init_done, init_error, restart, enable, mode, phase_inc, sample_req,
    output init_start, sample_out, sample_valid, state, error_code
  );
endinterface

// File: rtl/audio_wave_engine.sv
// Audio run controller: sequences codec bring-up (START -> INIT -> RUNNING /
// ERROR) with an init timeout and restart, and produces one frame of NUM_CH
// phase-accumulator waveforms per DAC sample request while RUNNING.
module audio_wave_engine #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_W     = 16,
  parameter int PHASE_W      = 24,
  parameter int ERR_W        = 4,
  parameter int INIT_TIMEOUT = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  audio_wave_engine_if.slave   io
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(INIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  localparam logic signed [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_POS   = ~MOST_NEG;
  localparam logic signed [SAMPLE_W-1:0] SQ_NEG   = -SQ_POS;

  state_t                            state_q;
  logic                              init_start_q;
  logic [ERR_W-1:0]                  err_q;
  logic [CNT_W-1:0]                  cnt_q;

  logic [NUM_CH-1:0][PHASE_W-1:0]    phase_p0;
  logic [NUM_CH-1:0][PHASE_W-1:0]    phase_nxt;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]   frame_nxt;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]   sample_p1;
  logic                              vld_p1;
  logic                              advance;

  // Map the top SAMPLE_W phase bits onto a signed waveform sample.
  function automatic logic signed [SAMPLE_W-1:0] shape_sample(
    input logic [1:0]          md,
    input logic [SAMPLE_W-1:0] p
  );
    logic [SAMPLE_W-2:0] t;
    t = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
    case (md)
      2'd0:    shape_sample = $signed(p ^ MOST_NEG);
      2'd1:    shape_sample = p[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
      2'd2:    shape_sample = $signed({t, 1'b0} ^ MOST_NEG);
      default: shape_sample = '0;
    endcase
  endfunction

  // Bring-up sequencer; restart outranks every other event except in START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_START;
      init_start_q <= 1'b0;
      err_q        <= '0;
      cnt_q        <= '0;
    end else begin
      init_start_q <= 1'b0;
      if (io.restart && state_q != ST_START) begin
        state_q <= ST_START;
        err_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_START: begin
            state_q      <= ST_INIT;
            init_start_q <= 1'b1;
            cnt_q        <= '0;
          end
          ST_INIT: begin
            if (|io.init_error) begin
              state_q <= ST_ERR;
              err_q   <= io.init_error;
            end else if (io.init_done) begin
              state_q <= ST_RUN;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_ERR;
              err_q   <= '1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next phases and the frame they produce; silence holds the accumulators.
  always_comb begin
    advance   = io.enable && (io.mode != 2'd3);
    phase_nxt = phase_p0;
    frame_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (advance) begin
        phase_nxt[c] = phase_p0[c] + io.phase_inc[c*PHASE_W +: PHASE_W];
        frame_nxt[c] = shape_sample(io.mode, phase_nxt[c][PHASE_W-1 -: SAMPLE_W]);
      end
    end
  end

  // Stage p0 -> p1: commit phases and register the frame on each request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_p0  <= '0;
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
    end else if (state_q != ST_RUN || io.restart) begin
      vld_p1    <= 1'b0;
      sample_p1 <= '0;
      if (io.restart && state_q != ST_START) begin
        phase_p0 <= '0;
      end
    end else begin
      vld_p1 <= io.sample_req;
      if (io.sample_req) begin
        phase_p0  <= phase_nxt;
        sample_p1 <= frame_nxt;
      end
    end
  end

  assign io.init_start   = init_start_q;
  assign io.state        = state_q;
  assign io.error_code   = err_q;
  assign io.sample_out   = sample_p1;
  assign io.sample_valid = vld_p1;

endmodule
